instr_fetch_unit: RTL and testbench

//  Instruction fetch stage that drives the memory system address port.
//  - Holds the PC and issues one word address at a time.
//  - Waits the configured memory read latency, then captures the returned word.
//  - Offers the word to decode with a valid/ready handshake.
//  - Accepts branch/jump redirects from execute.

---
 rtl/instr_fetch_unit.sv | 77 +++++++
 tb/tb_instr_fetch_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage that issues one word address at a time, waits the memory latency,
// captures the word and offers it to decode over a valid/ready handshake; accepts redirects.
// Ports: clk_i/rst_i (async active-high), enable_i, redirect_i/redirect_pc_i, mem_addr_o/mem_rdata_i,
// inst_o/inst_pc_o/inst_valid_o/inst_ready_i, fetch_count_o (only when FETCH_PERF_CNT_EN is defined).
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0040_0000,
    parameter int                    MEM_LATENCY = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [DATA_WIDTH-1:0] inst_pc_o,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0] fetch_count_o
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;
    state_t                r_state, w_next;
    logic [DATA_WIDTH-1:0] r_pc, r_inst, r_inst_pc;
    logic [1:0]            r_cnt;
    logic                  w_xfer, w_capture;
    assign w_xfer    = r_state == S_HOLD && inst_ready_i;
    // a redirect flushes the fetch in flight, so the word landing on that edge is dropped
    assign w_capture = !redirect_i && ((r_state == S_ISSUE && MEM_LATENCY == 0) ||
                                       (r_state == S_WAIT && r_cnt == 2'd1));
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (redirect_i) w_next = enable_i ? S_ISSUE : S_IDLE;
        else case (r_state)
            S_IDLE:  w_next = enable_i ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = MEM_LATENCY == 0 ? S_HOLD : S_WAIT;
            S_WAIT:  w_next = r_cnt == 2'd1 ? S_HOLD : S_WAIT;
            default: w_next = inst_ready_i ? (enable_i ? S_ISSUE : S_IDLE) : S_HOLD;
        endcase
    end
    always_comb begin
        inst_valid_o = r_state == S_HOLD;
        mem_addr_o   = r_pc;
        inst_o       = r_inst;
        inst_pc_o    = r_inst_pc;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            r_pc      <= RESET_PC;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_cnt     <= '0;
        end else begin
            // redirect wins over pc+4 even when the current word is handed over on the same edge
            if (redirect_i)  r_pc <= redirect_pc_i & ~DATA_WIDTH'(3);
            else if (w_xfer) r_pc <= r_pc + DATA_WIDTH'(4);
            if (w_capture) begin
                r_inst    <= mem_rdata_i;
                r_inst_pc <= r_pc;
            end
            r_cnt <= r_state == S_ISSUE ? 2'(MEM_LATENCY) : r_state == S_WAIT ? r_cnt - 2'd1 : r_cnt;
        end
`ifdef FETCH_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] r_fetch_count;
    assign fetch_count_o = r_fetch_count;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i)       r_fetch_count <= '0;
        else if (w_xfer) r_fetch_count <= r_fetch_count + DATA_WIDTH'(1);
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: vector table, directed corner sequences and random stimulus against a countdown model.
module tb_instr_fetch_unit;
    localparam int          ML = 1;
    localparam logic [31:0] RPC = 32'h0040_0000;
    logic        clk = 0, rst = 0, en = 0, rdy = 0, redir = 0, valid;
    logic [31:0] rpc = 0, mem_addr, rdata, inst, ipc;
    int          n_chk = 0, n_fail = 0;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt, c0;
`endif
    always #5 clk = ~clk;
    function automatic logic [31:0] word(logic [31:0] a);
        return ((a - RPC) >> 2) + 32'hA;
    endfunction
    assign rdata = word(mem_addr);
    instr_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RPC), .MEM_LATENCY(ML)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .redirect_i(redir), .redirect_pc_i(rpc),
        .mem_addr_o(mem_addr), .mem_rdata_i(rdata), .inst_o(inst), .inst_pc_o(ipc),
        .inst_valid_o(valid), .inst_ready_i(rdy)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count_o(fcnt)
`endif
    );
    // model: a fetch in flight lands m_left edges after it starts; pc only moves on handover or redirect
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;
    logic        m_valid;
    int          m_left;
    task automatic model_reset();
        m_pc = RPC; m_inst = 0; m_ipc = 0; m_valid = 0; m_left = -1; m_cnt = 0;
    endtask
    task automatic step();
        if (m_valid && rdy) m_cnt++;
        if (redir) begin
            m_pc = rpc & ~32'd3; m_valid = 0; m_left = en ? ML + 1 : -1;
        end else if (m_valid) begin
            if (rdy) begin m_pc += 4; m_valid = 0; m_left = en ? ML + 1 : -1; end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_valid = 1; m_inst = word(m_pc); m_ipc = m_pc; end
        end else if (en) m_left = ML + 1;
    endtask
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick(logic e, logic r, logic d, logic [31:0] p);
        en = e; rdy = r; redir = d; rpc = p;
        @(posedge clk); step();
        @(negedge clk);
    endtask
    task automatic do_reset();
        @(posedge clk); #3 rst = 1; #1;
        check("rst_addr", mem_addr, RPC);
        check("rst_valid", valid, 0);
        check("rst_inst", inst, 0);
        check("rst_ipc", ipc, 0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_cnt", fcnt, 0);
`endif
        model_reset(); en = 0; rdy = 0; redir = 0;
        @(negedge clk); rst = 0;
    endtask
    typedef struct {logic en, rdy, e_valid; logic [31:0] e_addr, e_inst, e_ipc;} vec_t;
    vec_t tbl[16];
    initial begin
        tbl[0] = '{1, 1, 0, 32'h400000, 0, 0};
        tbl[1] = '{1, 1, 0, 32'h400000, 0, 0};
        tbl[2] = '{1, 1, 1, 32'h400000, 32'hA, 32'h400000};
        tbl[3] = '{1, 1, 0, 32'h400004, 32'hA, 32'h400000};
        tbl[4] = '{1, 1, 0, 32'h400004, 32'hA, 32'h400000};
        tbl[5] = '{1, 1, 1, 32'h400004, 32'hB, 32'h400004};
        tbl[6] = '{1, 1, 0, 32'h400008, 32'hB, 32'h400004};
        tbl[7] = '{1, 1, 0, 32'h400008, 32'hB, 32'h400004};
        for (int i = 8; i < 14; i++) tbl[i] = '{1, 0, 1, 32'h400008, 32'hC, 32'h400008};
        tbl[14] = '{0, 1, 0, 32'h40000C, 32'hC, 32'h400008};
        tbl[15] = '{0, 1, 0, 32'h40000C, 32'hC, 32'h400008};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].en, tbl[i].rdy, 0, 0);
            check($sformatf("vec%0d_valid", i), valid, tbl[i].e_valid);
            check($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_inst", i), inst, tbl[i].e_inst);
            check($sformatf("vec%0d_ipc", i), ipc, tbl[i].e_ipc);
        end
        // redirect while waiting on memory: old fetch never becomes valid
        do_reset();
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        tick(1, 1, 1, 32'h1001_0003);
        check("redir_wait_valid", valid, 0);
        check("redir_wait_addr", mem_addr, 32'h1001_0000);
        tick(1, 1, 0, 0);
        check("redir_wait_valid2", valid, 0);
        tick(1, 0, 0, 0);
        check("redir_wait_valid3", valid, 1);
        check("redir_wait_ipc", ipc, 32'h1001_0000);
        check("redir_wait_inst", inst, word(32'h1001_0000));
        // redirect coinciding with a handover
        tick(1, 0, 1, 32'h0040_0010);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("hs_redir_hold", valid, 1);
        check("hs_redir_ipc0", ipc, 32'h400010);
`ifdef FETCH_PERF_CNT_EN
        c0 = fcnt;
`endif
        tick(1, 1, 1, 32'h0040_0100);
        check("hs_redir_addr", mem_addr, 32'h400100);
        check("hs_redir_valid", valid, 0);
`ifdef FETCH_PERF_CNT_EN
        check("hs_redir_cnt", fcnt, c0 + 1);
`endif
        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);
        check("hs_redir_ipc1", ipc, 32'h400100);
        check("hs_redir_inst1", inst, 32'hA + 32'h40);
        // PC wrap
        tick(1, 0, 1, 32'hFFFF_FFFC);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("wrap_ipc", ipc, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
        c0 = fcnt;
`endif
        tick(0, 1, 0, 0);
        check("wrap_addr", mem_addr, 32'h0);
        check("wrap_valid", valid, 0);
`ifdef FETCH_PERF_CNT_EN
        check("wrap_cnt", fcnt, c0 + 1);
`endif
        // random traffic against the model, with one reset dropped in mid-run
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom);
            check("rnd_valid", valid, m_valid);
            check("rnd_addr", mem_addr, m_pc);
            check("rnd_inst", inst, m_inst);
            check("rnd_ipc", ipc, m_ipc);
`ifdef FETCH_PERF_CNT_EN
            check("rnd_cnt", fcnt, m_cnt);
`endif
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
